// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: iterative multiply/divide unit for the Execute stage.
// Handshake: Start is a request that is taken only in IDLE when Abort is low;
// Busy is high from the accepting cycle until the last COMPUTE cycle; Done is
// a one-cycle pulse in DONE, when Result1/Result2 already hold the answer.
// Results stay put until the next accepted operation completes or reset.
module mcycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       DbgState
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;         // negate product / quotient
    logic                 rem_neg_q, rem_neg_d; // remainder follows dividend sign
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     op1_q, op1_d;         // raw dividend for divide-by-zero
    logic [WIDTH-1:0]     mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;         // product accumulator / quotient in low half
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     result1_q, result1_d;
    logic [WIDTH-1:0]     result2_q, result2_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, prod_fix;
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_q_next, div_rem_next;

    // Operand magnitudes and one shift-add / restoring-divide step.
    always_comb begin
        a_neg        = MCycleOp[0] & Operand1[WIDTH-1];
        b_neg        = MCycleOp[0] & Operand2[WIDTH-1];
        a_mag        = a_neg ? (~Operand1 + 1'b1) : Operand1;
        b_mag        = b_neg ? (~Operand2 + 1'b1) : Operand2;
        mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
        prod_fix     = neg_q ? (~mul_next + 1'b1) : mul_next;
        div_shift    = {rem_q, acc_q[WIDTH-1]};
        div_ok       = (div_shift >= {1'b0, mcand_q});
        div_rem_next = div_ok ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];
        div_q_next   = {acc_q[WIDTH-2:0], div_ok};
    end

    // Next-state, datapath updates and combinational outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        op1_d     = op1_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        result1_d = result1_q;
        result2_d = result2_q;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    Busy      = ~RESET;
                    state_d   = COMPUTE;
                    count_d   = CW'(WIDTH);
                    is_div_d  = MCycleOp[1];
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    div0_d    = (Operand2 == '0);
                    op1_d     = Operand1;
                    mcand_d   = MCycleOp[1] ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, MCycleOp[1] ? a_mag : b_mag};
                    rem_d     = '0;
                end
            end
            COMPUTE: begin
                if (Abort) begin
                    state_d = IDLE;
                end else begin
                    Busy    = ~RESET;
                    count_d = count_q - 1'b1;
                    if (is_div_q) begin
                        acc_d = {{WIDTH{1'b0}}, div_q_next};
                        rem_d = div_rem_next;
                    end else begin
                        acc_d = mul_next;
                    end
                    if (count_q == CW'(1)) begin
                        state_d = DONE;
                        if (!is_div_q) begin
                            result1_d = prod_fix[WIDTH-1:0];
                            result2_d = prod_fix[2*WIDTH-1:WIDTH];
                        end else if (div0_q) begin
                            result1_d = '1;
                            result2_d = op1_q;
                        end else begin
                            result1_d = neg_q ? (~div_q_next + 1'b1) : div_q_next;
                            result2_d = rem_neg_q ? (~div_rem_next + 1'b1) : div_rem_next;
                        end
                    end
                end
            end
            DONE: begin
                Done    = ~Abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            op1_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            op1_q     <= op1_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
        end
    end

    assign Result1  = result1_q;
    assign Result2  = result2_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: directed cases, random operations
// against an arithmetic reference model, and Abort/Start/RESET control cases.
module tb_mcycle_ctrl;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic         Abort;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy, Done;
    logic [1:0]   DbgState;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_r1, exp_r2;   // results the DUT should currently hold
    logic [W-1:0] exp_q[$];         // expected {r1, r2} pairs for the op in flight

    mcycle_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Abort(Abort), .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
        .DbgState(DbgState)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] r1, output logic [W-1:0] r2);
        logic [63:0] p;
        longint sa, sb, q, r;
        if (!op[1]) begin
            if (op[0]) p = longint'($signed(a)) * longint'($signed(b));
            else       p = {32'b0, a} * {32'b0, b};
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == 0) begin
            r1 = '1;
            r2 = a;
        end else if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            r1 = q[31:0];
            r2 = r[31:0];
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endfunction

    // Drive one operation from cycle 0 and check Busy/Done every cycle up to DONE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold_start);
        logic [W-1:0] m1, m2;
        model(op, a, b, m1, m2);
        exp_q.push_back(m1);
        exp_q.push_back(m2);
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        @(negedge CLK);
        check("busy_c0", Busy, 1);
        check("done_c0", Done, 0);
        for (int c = 1; c <= W + 1; c++) begin
            @(posedge CLK); #1;
            if (!hold_start) Start = 1'b0;
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCycleOp = 2'($urandom_range(0, 3));
            @(negedge CLK);
            check($sformatf("busy_c%0d", c), Busy, (c <= W) ? 1 : 0);
            check($sformatf("done_c%0d", c), Done, (c == W + 1) ? 1 : 0);
        end
        exp_r1 = exp_q.pop_front();
        exp_r2 = exp_q.pop_front();
        check("result1", Result1, exp_r1);
        check("result2", Result2, exp_r2);
        if (hold_start) begin
            @(posedge CLK); #1;
            Start = 1'b0;
            @(negedge CLK);
            check("hold_done_once", Done, 0);
            check("hold_no_restart", Busy, 0);
            check("hold_r1", Result1, exp_r1);
        end
    endtask

    // Start an op and abort it in cycle 10; nothing about the results may change.
    task automatic abort_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int dones = 0;
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK); #1;
            Start = 1'b0;
            if (c == 10) Abort = 1'b1;
        end
        @(negedge CLK);
        check("abort_busy_c10", Busy, 0);
        for (int c = 11; c <= W + 4; c++) begin
            @(posedge CLK); #1;
            Abort = 1'b0;
            @(negedge CLK);
            if (Done) dones++;
            if (c == 11) check("abort_idle", Busy, 0);
        end
        check("abort_no_done", dones, 0);
        check("abort_r1_kept", Result1, exp_r1);
        check("abort_r2_kept", Result2, exp_r2);
    endtask

    initial begin
        logic [W-1:0] corner [5];
        logic [1:0]   op;
        logic [W-1:0] a, b;
        int           dones;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

        // Reset
        RESET = 1'b1; Start = 1'b1; Abort = 1'b0; MCycleOp = 2'b00;
        Operand1 = '0; Operand2 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_r1", Result1, 0);
        check("rst_r2", Result2, 0);
        #1 Start = 1'b0;
        @(posedge CLK); #1 RESET = 1'b0;
        exp_r1 = '0; exp_r2 = '0;

        // Directed cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("umul_r1", Result1, 32'h0000_0001);
        check("umul_r2", Result2, 32'hFFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
        check("smul_r1", Result1, 32'hFFFF_FFEB);
        check("smul_r2", Result2, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd100, 32'd7, 0);
        check("udiv_r1", Result1, 32'd14);
        check("udiv_r2", Result2, 32'd2);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        check("sdiv_r1", Result1, 32'hFFFF_FFFD);
        check("sdiv_r2", Result2, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h1234_5678, 32'd0, 0);
        check("div0_r1", Result1, 32'hFFFF_FFFF);
        check("div0_r2", Result2, 32'h1234_5678);
        run_op(2'b11, 32'h8000_0000, 32'd0, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);

        // Start held through DONE
        run_op(2'b01, 32'd12345, 32'hFFFF_0000, 1);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a = corner[$urandom_range(0, 4)]; b = corner[$urandom_range(0, 4)]; end
                1: begin a = $urandom; b = 32'($urandom_range(0, 15)); end
                2: begin a = $urandom; b = (32'($urandom_range(1, 255)) ^ {32{$urandom_range(0, 1) == 1}}); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(op, a, b, 0);
        end

        // Abort overrides Start in IDLE
        @(posedge CLK); #1;
        Start = 1'b1; Abort = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd5;
        @(negedge CLK);
        check("abort_vs_start_busy", Busy, 0);
        @(posedge CLK); #1;
        Start = 1'b0; Abort = 1'b0;
        @(negedge CLK);
        check("abort_vs_start_idle", Busy, 0);

        // Abort mid-COMPUTE
        abort_op(2'b00, 32'd9, 32'd9);
        abort_op(2'b11, 32'hFFFF_FF00, 32'd3);

        // RESET mid-COMPUTE
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'h1234;
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK); #1;
            Start = 1'b0;
        end
        RESET = 1'b1;
        #1;
        check("rst_mid_r1", Result1, 0);
        check("rst_mid_r2", Result2, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_done", Done, 0);
        @(posedge CLK); #1 RESET = 1'b0;
        exp_r1 = '0; exp_r2 = '0;
        dones = 0;
        repeat (W + 4) begin
            @(negedge CLK);
            if (Done || Busy) dones++;
        end
        check("rst_mid_quiet", dones, 0);
        check("rst_mid_hold_r1", Result1, exp_r1);

        // Unit still works after reset
        run_op(2'b10, 32'd1000, 32'd33, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
